ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Next-generation ID-stage control: full opcode/funct decode plus a registered ID/EX control
//  register with bubble insertion, flush, a multi-cycle MULT/DIV sequencer and stall generation.
//  Sits between the IF/ID register and the EX stage. Its stall drives the PC and IF/ID enables.
//  Outputs feed the EX stage directly, one cycle after decode.
// PARAMETERS
//  ALUOP_W     4  width of ALUOp; the ALU_* codes in const.v must fit in it
//  MULDIV_LAT  8  EX occupancy of MULT/DIV in cycles; legal range 2..255
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        synchronous reset, active-high
//  id_valid  in   1        IF/ID holds a real instruction (0 = empty slot)
//  opcode    in   6        instr[31:26]
//  funct     in   6        instr[5:0]
//  rs        in   5        instr[25:21]
//  rt        in   5        instr[20:16]
//  hazard    in   1        external bubble request
//  flush     in   1        taken branch/jump resolved; kill the ID instruction
//  ALUOp     out  ALUOP_W  registered ALU operation
//  ExtType   out  1        registered; 1 = sign-extend, 0 = zero-extend
//  IsImd, IsShift, Link, MemRead, MemWrite, NotEqual, RegWrite   out  1  registered
//  PCSrc     out  2        registered; 0 = seq, 1 = branch, 2 = jump, 3 = jr
//  MdStart   out  1        registered; 1-cycle pulse, MULT/DIV entering EX
//  MdSel     out  1        registered; 0 = MULT, 1 = DIV (valid with MdStart)
//  md_busy   out  1        registered; multiplier/divider occupied
//  stall     out  1        combinational; hold PC and IF/ID this cycle
// BEHAVIOUR
//  Decode table, existing opcodes:
//   - ADD, AND, OR, SUB, SLT, SLL, SRA, SRL, JR, ADDI, BEQ, BNE, J, JAL, LUI, LW, ORI, SW.
//   - Same ALUOp, IsImd, IsShift, PCSrc and RegWrite values as the current ID decode.
//   - ExtType = (opcode != I_ORI); Link = JAL; MemRead = LW; MemWrite = SW; NotEqual = BNE.
//  Decode table, new R-type funct codes (values added to const.v):
//   - MULT 6'h18: MdStart = 1, MdSel = 0, RegWrite = 0.
//   - DIV 6'h1A: MdStart = 1, MdSel = 1, RegWrite = 0.
//   - MFHI 6'h10: ALUOp = ALU_MFHI, RegWrite = 1.
//   - MFLO 6'h12: ALUOp = ALU_MFLO, RegWrite = 1.
//  Undefined opcode or funct decodes to all zeros (NOP).
//  bubble = ~id_valid | hazard | flush | stall.
//  Every posedge:
//   - rst: all registered outputs <= 0, FSM -> IDLE, counter <= 0.
//   - bubble: all ID/EX control outputs <= 0, including MdStart.
//   - otherwise: ID/EX control outputs <= decode. Latency is 1 cycle.
//  md_is = decoded MULT/DIV; md_rd = decoded MFHI/MFLO.
//  MULT/DIV FSM:
//   - IDLE: on an unbubbled md_is, cnt <= MULDIV_LAT-1 and go to BUSY. md_busy is 1 from the next cycle.
//   - BUSY: cnt decrements each cycle. At cnt == 1 go to IDLE, so md_busy is high for MULDIV_LAT-1 cycles after MdStart.
//   - flush and hazard do not cancel BUSY; the operation is already in EX.
//   - counter width is $clog2(MULDIV_LAT).
//  Structural stall:
//   - md_stall = id_valid & (md_is | md_rd) & md_busy.
//   - The first MFHI/MFLO after the FSM reaches IDLE passes with no extra cycle.
//  Total stall = (md_stall | lu_stall) & ~flush.
//   - flush wins: stall is 0 and a bubble is inserted.
//   - The external hazard does not raise stall; the hazard source owns its own stall.
//  Simultaneous events:
//   - md_is with md_busy: stall, and the FSM is not reloaded.
//   - md_is with flush in IDLE: not issued, FSM stays IDLE.
//  Reset mid-BUSY: FSM -> IDLE next edge and md_busy drops; the in-flight result is abandoned.
// CONFIGURATION
//  LOAD_USE_DETECT_EN defined:
//   - Internal load-use detection. On every unbubbled issue the block registers ex_ld <= decoded MemRead
//     and ex_rt <= rt; on a bubble, ex_ld <= 0.
//   - uses_rs = every decode except J, JAL, LUI, SLL, SRA, SRL, MFHI, MFLO.
//   - uses_rt = R-type ALU ops, SLL, SRA, SRL, MULT, DIV, BEQ, BNE, SW.
//   - lu_stall = id_valid & ex_ld & (ex_rt != 0) & ((uses_rs & rs == ex_rt) | (uses_rt & rt == ex_rt)).
//   - The stall lasts exactly 1 cycle per load.
//  LOAD_USE_DETECT_EN undefined:
//   - lu_stall = 0 and no ex_ld/ex_rt registers exist.
//   - Load-use hazards are handled only through the hazard port.
// TESTING
//  1. rst held 2 cycles, then ADDI with id_valid = 1.
//     -> All outputs 0 during reset. Next cycle: ALUOp = ALU_ADD, IsImd = 1, RegWrite = 1, ExtType = 1.
//  2. MULT, then DIV on the next cycle (MULDIV_LAT = 8).
//     -> MdStart pulses 1 cycle with MdSel = 0. md_busy is high 7 cycles.
//     -> stall is high for the DIV for those 7 cycles, then the DIV issues with MdSel = 1.
//  3. MFLO 3 cycles after MULT (MULDIV_LAT = 4).
//     -> stall for exactly 1 cycle, then MFLO issues with RegWrite = 1.
//  4. flush asserted on the same cycle as a BEQ in ID, and separately with MULT in ID while IDLE.
//     -> Outputs all 0 next cycle, stall = 0, md_busy stays 0.
//  5. With LOAD_USE_DETECT_EN: LW rt = 5, then ADD rs = 5.
//     -> stall = 1 for 1 cycle, a bubble is inserted, then the ADD issues.
//     -> Also LW rt = 0, then ADD rs = 0: no stall.
//  6. rst asserted mid-BUSY (cnt = 3).
//     -> Next cycle md_busy = 0, the FSM is IDLE, and a new MULT issues with no stall.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: groups the signals between the IF/ID register, ctrl_pipe and the EX stage.
//   master: drives the ID-side inputs and receives the ID/EX controls and stall
//           (the IF/ID side plus the EX stage).
//   slave : ctrl_pipe itself.
//   ID-side inputs : id_valid, opcode, funct, rs, rt, hazard, flush
//   ID/EX controls : ALUOp, ExtType, IsImd, IsShift, Link, MemRead, MemWrite,
//                    NotEqual, RegWrite, PCSrc, MdStart, MdSel, md_busy
//   stall          : combinational hold request for the PC and IF/ID
interface ctrl_pipe_if #(
   parameter int unsigned ALUOP_W = 4
);
   logic               id_valid;
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [4:0]         rs;
   logic [4:0]         rt;
   logic               hazard;
   logic               flush;
   logic [ALUOP_W-1:0] ALUOp;
   logic               ExtType;
   logic               IsImd;
   logic               IsShift;
   logic               Link;
   logic               MemRead;
   logic               MemWrite;
   logic               NotEqual;
   logic               RegWrite;
   logic [1:0]         PCSrc;
   logic               MdStart;
   logic               MdSel;
   logic               md_busy;
   logic               stall;

   modport master (
      output id_valid, opcode, funct, rs, rt, hazard, flush,
      input  ALUOp, ExtType, IsImd, IsShift, Link, MemRead, MemWrite,
             NotEqual, RegWrite, PCSrc, MdStart, MdSel, md_busy, stall
   );

   modport slave (
      input  id_valid, opcode, funct, rs, rt, hazard, flush,
      output ALUOp, ExtType, IsImd, IsShift, Link, MemRead, MemWrite,
             NotEqual, RegWrite, PCSrc, MdStart, MdSel, md_busy, stall
   );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID-stage decode with a registered ID/EX control register, bubble
// insertion, flush, a MULT/DIV occupancy sequencer and structural stall.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ctrl_pipe_if.slave (ID-side inputs, ID/EX controls, md_busy, stall)
// Parameters: ALUOP_W (ALUOp width), MULDIV_LAT (MULT/DIV EX occupancy, 2..255).
// Optional macro LOAD_USE_DETECT_EN: adds internal load-use detection (ex_ld/ex_rt
// registers feeding the stall); without it load-use goes through the hazard port.
module ctrl_pipe #(
   parameter int unsigned ALUOP_W    = 4,
   parameter int unsigned MULDIV_LAT = 8
) (
   input  logic         clk,
   input  logic         rst,
   ctrl_pipe_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(MULDIV_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

   // opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   // R-type funct codes
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_MFHI = 6'h10;
   localparam logic [5:0] F_MFLO = 6'h12;
   localparam logic [5:0] F_MULT = 6'h18;
   localparam logic [5:0] F_DIV  = 6'h1A;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2A;
   // ALU operations (0 is reserved for the NOP/bubble encoding)
   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(9);
   localparam logic [ALUOP_W-1:0] ALU_MFHI = ALUOP_W'(10);
   localparam logic [ALUOP_W-1:0] ALU_MFLO = ALUOP_W'(11);

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               ext_type;
      logic               is_imd;
      logic               is_shift;
      logic               link;
      logic               mem_read;
      logic               mem_write;
      logic               not_equal;
      logic               reg_write;
      logic [1:0]         pc_src;
      logic               md_start;
      logic               md_sel;
   } ctrl_t;

   typedef enum logic {IDLE, BUSY} md_state_e;

   ctrl_t            dec;
   logic             known;
   logic             md_is;
   logic             md_rd;
   ctrl_t            ctrl_d, ctrl_q;
   md_state_e        state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             md_busy;
   logic             md_stall;
   logic             lu_stall;
   logic             stall;
   logic             bubble;

   // ---------------- decode ----------------
   always_comb begin
      dec   = '0;
      known = 1'b0;
      md_is = 1'b0;
      md_rd = 1'b0;
      case (bus.opcode)
         OP_RTYPE: begin
            known = 1'b1;
            case (bus.funct)
               F_ADD:  begin dec.alu_op = ALU_ADD; dec.reg_write = 1'b1; end
               F_SUB:  begin dec.alu_op = ALU_SUB; dec.reg_write = 1'b1; end
               F_AND:  begin dec.alu_op = ALU_AND; dec.reg_write = 1'b1; end
               F_OR:   begin dec.alu_op = ALU_OR;  dec.reg_write = 1'b1; end
               F_SLT:  begin dec.alu_op = ALU_SLT; dec.reg_write = 1'b1; end
               F_SLL:  begin dec.alu_op = ALU_SLL; dec.is_shift = 1'b1; dec.reg_write = 1'b1; end
               F_SRL:  begin dec.alu_op = ALU_SRL; dec.is_shift = 1'b1; dec.reg_write = 1'b1; end
               F_SRA:  begin dec.alu_op = ALU_SRA; dec.is_shift = 1'b1; dec.reg_write = 1'b1; end
               F_JR:   dec.pc_src = 2'd3;
               F_MULT: begin dec.md_start = 1'b1; md_is = 1'b1; end
               F_DIV:  begin dec.md_start = 1'b1; dec.md_sel = 1'b1; md_is = 1'b1; end
               F_MFHI: begin dec.alu_op = ALU_MFHI; dec.reg_write = 1'b1; md_rd = 1'b1; end
               F_MFLO: begin dec.alu_op = ALU_MFLO; dec.reg_write = 1'b1; md_rd = 1'b1; end
               default: known = 1'b0;
            endcase
         end
         OP_ADDI: begin known = 1'b1; dec.alu_op = ALU_ADD; dec.is_imd = 1'b1; dec.reg_write = 1'b1; end
         OP_ORI:  begin known = 1'b1; dec.alu_op = ALU_OR;  dec.is_imd = 1'b1; dec.reg_write = 1'b1; end
         OP_LUI:  begin known = 1'b1; dec.alu_op = ALU_LUI; dec.is_imd = 1'b1; dec.reg_write = 1'b1; end
         OP_LW:   begin
            known = 1'b1; dec.alu_op = ALU_ADD; dec.is_imd = 1'b1;
            dec.mem_read = 1'b1; dec.reg_write = 1'b1;
         end
         OP_SW:   begin known = 1'b1; dec.alu_op = ALU_ADD; dec.is_imd = 1'b1; dec.mem_write = 1'b1; end
         OP_BEQ:  begin known = 1'b1; dec.alu_op = ALU_SUB; dec.pc_src = 2'd1; end
         OP_BNE:  begin known = 1'b1; dec.alu_op = ALU_SUB; dec.pc_src = 2'd1; dec.not_equal = 1'b1; end
         OP_J:    begin known = 1'b1; dec.pc_src = 2'd2; end
         OP_JAL:  begin known = 1'b1; dec.pc_src = 2'd2; dec.link = 1'b1; dec.reg_write = 1'b1; end
         default: known = 1'b0;
      endcase
      // undefined encodings must stay all-zero, so ExtType is gated by a legal decode
      dec.ext_type = known & (bus.opcode != OP_ORI);
   end

   // ---------------- load-use detection ----------------
`ifdef LOAD_USE_DETECT_EN
   logic       ex_ld_d, ex_ld_q;
   logic [4:0] ex_rt_d, ex_rt_q;
   logic       uses_rs;
   logic       uses_rt;

   always_comb begin
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (bus.opcode)
         OP_RTYPE: begin
            case (bus.funct)
               F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULT, F_DIV: begin
                  uses_rs = 1'b1;
                  uses_rt = 1'b1;
               end
               F_SLL, F_SRL, F_SRA: uses_rt = 1'b1;
               F_JR:                uses_rs = 1'b1;
               default: ;
            endcase
         end
         OP_ADDI, OP_ORI, OP_LW: uses_rs = 1'b1;
         OP_BEQ, OP_BNE, OP_SW: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      lu_stall = bus.id_valid & ex_ld_q & (ex_rt_q != '0) &
                 ((uses_rs & (bus.rs == ex_rt_q)) | (uses_rt & (bus.rt == ex_rt_q)));
   end

   // a bubble clears ex_ld, which is what limits the stall to one cycle per load
   always_comb begin
      ex_ld_d = bubble ? 1'b0 : dec.mem_read;
      ex_rt_d = bubble ? ex_rt_q : bus.rt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ld_q <= 1'b0;
         ex_rt_q <= '0;
      end else begin
         ex_ld_q <= ex_ld_d;
         ex_rt_q <= ex_rt_d;
      end
   end
`else
   logic unused_regs;
   assign unused_regs = ^{bus.rs, bus.rt};

   always_comb begin
      lu_stall = 1'b0;
   end
`endif

   // ---------------- stall / bubble ----------------
   always_comb begin
      md_stall = bus.id_valid & (md_is | md_rd) & md_busy;
      stall    = (md_stall | lu_stall) & ~bus.flush;
      bubble   = ~bus.id_valid | bus.hazard | bus.flush | stall;
      ctrl_d   = bubble ? '0 : dec;
   end

   // ---------------- ID/EX register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   // ---------------- MULT/DIV sequencer ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (md_is && !bubble) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      md_busy = (state_q == BUSY);
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.ALUOp    = ctrl_q.alu_op;
      bus.ExtType  = ctrl_q.ext_type;
      bus.IsImd    = ctrl_q.is_imd;
      bus.IsShift  = ctrl_q.is_shift;
      bus.Link     = ctrl_q.link;
      bus.MemRead  = ctrl_q.mem_read;
      bus.MemWrite = ctrl_q.mem_write;
      bus.NotEqual = ctrl_q.not_equal;
      bus.RegWrite = ctrl_q.reg_write;
      bus.PCSrc    = ctrl_q.pc_src;
      bus.MdStart  = ctrl_q.md_start;
      bus.MdSel    = ctrl_q.md_sel;
      bus.md_busy  = md_busy;
      bus.stall    = stall;
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe. Two instances share one stimulus
// stream: dut8 (MULDIV_LAT = 8) and dut4 (MULDIV_LAT = 4).
module tb_ctrl_pipe;

   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                          OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRA = 6'h03, F_JR = 6'h08, F_MFHI = 6'h10,
                          F_MFLO = 6'h12, F_MULT = 6'h18, F_DIV = 6'h1A, F_ADD = 6'h20,
                          F_SUB = 6'h22, F_SLT = 6'h2A;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ctrl_pipe_if #(.ALUOP_W(4)) if8 ();
   ctrl_pipe_if #(.ALUOP_W(4)) if4 ();

   ctrl_pipe #(.ALUOP_W(4), .MULDIV_LAT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   ctrl_pipe #(.ALUOP_W(4), .MULDIV_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   // {ALUOp, ExtType, IsImd, IsShift, Link, MemRead, MemWrite, NotEqual, RegWrite, PCSrc, MdStart, MdSel}
   function automatic logic [15:0] cv(input logic [3:0] alu, input logic ext, imd, sh, lk,
                                      input logic mr, mw, ne, rw, input logic [1:0] pc,
                                      input logic ms, msel);
      return {alu, ext, imd, sh, lk, mr, mw, ne, rw, pc, ms, msel};
   endfunction

   function automatic logic [15:0] out8();
      return {if8.ALUOp, if8.ExtType, if8.IsImd, if8.IsShift, if8.Link, if8.MemRead,
              if8.MemWrite, if8.NotEqual, if8.RegWrite, if8.PCSrc, if8.MdStart, if8.MdSel};
   endfunction

   function automatic logic [15:0] out4();
      return {if4.ALUOp, if4.ExtType, if4.IsImd, if4.IsShift, if4.Link, if4.MemRead,
              if4.MemWrite, if4.NotEqual, if4.RegWrite, if4.PCSrc, if4.MdStart, if4.MdSel};
   endfunction

   task automatic drive(input logic v, input logic [5:0] op, fn, input logic [4:0] s, t,
                        input logic hz, fl);
      if8.id_valid = v; if8.opcode = op; if8.funct = fn; if8.rs = s; if8.rt = t;
      if8.hazard = hz; if8.flush = fl;
      if4.id_valid = v; if4.opcode = op; if4.funct = fn; if4.rs = s; if4.rt = t;
      if4.hazard = hz; if4.flush = fl;
   endtask

   task automatic nop();
      drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nop();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, OP_ADDI, 6'h00, 5'd1, 5'd2, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if (out8() !== 16'h0 || if8.md_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_c%0d: got ctrl=%h busy=%b want ctrl=0000 busy=0", i, out8(), if8.md_busy);
         end
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (out8() !== cv(4'd1, 1, 1, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0)) begin
         n_bad++;
         $display("FAIL addi_after_reset: got %h want %h", out8(), cv(4'd1, 1, 1, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0));
      end
   endtask

   task automatic test_decode();
      logic [5:0]  ops [12] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ORI, OP_SW, OP_LUI};
      logic [5:0]  fns [12] = '{F_SUB, F_SLT, F_SLL, F_SRA, F_JR, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      logic [15:0] exp [12] = '{cv(4'd2, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0),
                                cv(4'd5, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0),
                                cv(4'd6, 1, 0, 1, 0, 0, 0, 0, 1, 2'd0, 0, 0),
                                cv(4'd8, 1, 0, 1, 0, 0, 0, 0, 1, 2'd0, 0, 0),
                                cv(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 0),
                                cv(4'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0),
                                cv(4'd2, 1, 0, 0, 0, 0, 0, 1, 0, 2'd1, 0, 0),
                                cv(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0),
                                cv(4'd0, 1, 0, 0, 1, 0, 0, 0, 1, 2'd2, 0, 0),
                                cv(4'd4, 0, 1, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0),
                                cv(4'd1, 1, 1, 0, 0, 0, 1, 0, 0, 2'd0, 0, 0),
                                cv(4'd9, 1, 1, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0)};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, ops[i], fns[i], 5'd0, 5'd0, 1'b0, 1'b0);
         step();
         n_cmp++;
         if (out8() !== exp[i]) begin
            n_bad++;
            $display("FAIL decode_%0d op=%h fn=%h: got %h want %h", i, ops[i], fns[i], out8(), exp[i]);
         end
      end
      drive(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (out8() !== 16'h0) begin
         n_bad++;
         $display("FAIL decode_bad_opcode: got %h want 0000", out8());
      end
      drive(1'b1, OP_R, 6'h3F, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (out8() !== 16'h0) begin
         n_bad++;
         $display("FAIL decode_bad_funct: got %h want 0000", out8());
      end
      drive(1'b1, OP_R, F_MFHI, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (out8() !== cv(4'd10, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0)) begin
         n_bad++;
         $display("FAIL decode_mfhi_idle: got %h want %h", out8(), cv(4'd10, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0));
      end
      nop();
   endtask

   task automatic test_muldiv();
      do_reset();
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (out8() !== cv(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0)) begin
         n_bad++;
         $display("FAIL mult_issue: got %h want %h", out8(), cv(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
      end
      drive(1'b1, OP_R, F_DIV, 5'd3, 5'd4, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 7; k++) begin
         n_cmp++;
         if (if8.md_busy !== 1'b1 || if8.stall !== 1'b1 || (k > 0 && if8.MdStart !== 1'b0)) begin
            n_bad++;
            $display("FAIL div_stall_%0d: got busy=%b stall=%b start=%b want busy=1 stall=1 start=%0d",
                     k, if8.md_busy, if8.stall, if8.MdStart, (k == 0));
         end
         step();
      end
      n_cmp++;
      if (if8.md_busy !== 1'b0 || if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL div_release: got busy=%b stall=%b want 0 0", if8.md_busy, if8.stall);
      end
      step();
      n_cmp++;
      if (out8() !== cv(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1)) begin
         n_bad++;
         $display("FAIL div_issue: got %h want %h", out8(), cv(4'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1));
      end
      nop();
      step();
      n_cmp++;
      if (if8.MdStart !== 1'b0 || if8.md_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL div_pulse: got start=%b busy=%b want start=0 busy=1", if8.MdStart, if8.md_busy);
      end
   endtask

   task automatic test_mflo();
      do_reset();
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b0, 1'b0);
      step();
      nop();
      step();
      step();
      drive(1'b1, OP_R, F_MFLO, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (if4.stall !== 1'b1 || if4.md_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mflo_stall: got stall=%b busy=%b want 1 1", if4.stall, if4.md_busy);
      end
      step();
      n_cmp++;
      if (if4.stall !== 1'b0 || if4.md_busy !== 1'b0 || out4() !== 16'h0) begin
         n_bad++;
         $display("FAIL mflo_bubble: got stall=%b busy=%b ctrl=%h want 0 0 0000", if4.stall, if4.md_busy, out4());
      end
      step();
      n_cmp++;
      if (out4() !== cv(4'd11, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0)) begin
         n_bad++;
         $display("FAIL mflo_issue: got %h want %h", out4(), cv(4'd11, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0));
      end
      nop();
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, OP_BEQ, 6'h00, 5'd1, 5'd2, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_beq_stall: got %b want 0", if8.stall);
      end
      step();
      n_cmp++;
      if (out8() !== 16'h0) begin
         n_bad++;
         $display("FAIL flush_beq: got %h want 0000", out8());
      end
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b0, 1'b1);
      step();
      n_cmp++;
      if (out8() !== 16'h0 || if8.md_busy !== 1'b0 || if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL flush_mult: got ctrl=%h busy=%b stall=%b want 0000 0 0", out8(), if8.md_busy, if8.stall);
      end
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL hazard_nostall: got %b want 0", if8.stall);
      end
      step();
      n_cmp++;
      if (out8() !== 16'h0 || if8.md_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL hazard_mult: got ctrl=%h busy=%b want 0000 0", out8(), if8.md_busy);
      end
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_R, F_DIV, 5'd1, 5'd2, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (if8.stall !== 1'b0 || if8.md_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_wins: got stall=%b busy=%b want 0 1", if8.stall, if8.md_busy);
      end
      step();
      n_cmp++;
      if (out8() !== 16'h0 || if8.md_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_survives_flush: got ctrl=%h busy=%b want 0000 1", out8(), if8.md_busy);
      end
      nop();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, OP_LW, 6'h00, 5'd0, 5'd5, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (out8() !== cv(4'd1, 1, 1, 0, 0, 1, 0, 0, 1, 2'd0, 0, 0)) begin
         n_bad++;
         $display("FAIL lw_issue: got %h want %h", out8(), cv(4'd1, 1, 1, 0, 0, 1, 0, 0, 1, 2'd0, 0, 0));
      end
      drive(1'b1, OP_R, F_ADD, 5'd5, 5'd0, 1'b0, 1'b0);
      #1;
`ifdef LOAD_USE_DETECT_EN
      n_cmp++;
      if (if8.stall !== 1'b1) begin
         n_bad++;
         $display("FAIL lu_stall: got %b want 1", if8.stall);
      end
      step();
      n_cmp++;
      if (out8() !== 16'h0 || if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL lu_bubble: got ctrl=%h stall=%b want 0000 0", out8(), if8.stall);
      end
`else
      n_cmp++;
      if (if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL no_lu_stall: got %b want 0", if8.stall);
      end
`endif
      step();
      n_cmp++;
      if (out8() !== cv(4'd1, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0)) begin
         n_bad++;
         $display("FAIL add_after_lw: got %h want %h", out8(), cv(4'd1, 1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0));
      end
      drive(1'b1, OP_LW, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, OP_R, F_ADD, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL lw_r0_nostall: got %b want 0", if8.stall);
      end
      nop();
   endtask

   task automatic test_reset_busy();
      do_reset();
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b0, 1'b0);
      step();
      nop();
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (if8.md_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_before_rst: got %b want 1", if8.md_busy);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if (if8.md_busy !== 1'b0 || out8() !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_mid_busy: got busy=%b ctrl=%h want 0 0000", if8.md_busy, out8());
      end
      drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (if8.stall !== 1'b0) begin
         n_bad++;
         $display("FAIL mult_after_rst_stall: got %b want 0", if8.stall);
      end
      step();
      n_cmp++;
      if (if8.MdStart !== 1'b1 || if8.md_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mult_reissue: got start=%b busy=%b want 1 1", if8.MdStart, if8.md_busy);
      end
      nop();
   endtask

   initial begin
      rst = 1'b1;
      nop();
      test_reset();
      test_decode();
      test_muldiv();
      test_mflo();
      test_flush();
      test_load_use();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
